gerenciador_atributos: RTL and testbench

Owns and sequences the three pet attribute registers (fome, felicidade, sono) that feed the state controller. A free-running prescaler generates a periodic tick. On each tick, a small FSM applies per-state increments/decrements to the three attributes, one per cycle, through a single shared saturating add/sub unit. The block sits between the state controller (which supplies estado and consumes the attributes) and the display logic.

---
 rtl/pacote_tamagotchi.sv | 11 +
 rtl/gerenciador_atributos_somador_saturado.sv | 31 +++
 rtl/gerenciador_atributos.sv | 158 +++++++++++++++
 tb/tb_gerenciador_atributos.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pacote_tamagotchi.sv
// Shared definitions for the tamagotchi blocks: one-hot pet states and attribute width.
package pacote_tamagotchi;
    localparam int ATTR_W = 8;

    localparam logic [4:0] INTRO      = 5'b00000;
    localparam logic [4:0] IDLE       = 5'b00001;
    localparam logic [4:0] DORMINDO   = 5'b00010;
    localparam logic [4:0] COMENDO    = 5'b00100;
    localparam logic [4:0] DANDO_AULA = 5'b01000;
    localparam logic [4:0] MORTO      = 5'b10000;
endpackage

// File: rtl/gerenciador_atributos_somador_saturado.sv
// Combinational add/sub of a 9-bit delta to an 8-bit attribute, clamped to [0,255].
module somador_saturado
    import pacote_tamagotchi::*;
(
    input  logic [ATTR_W-1:0] operando,
    input  logic [ATTR_W:0]   delta,
    input  logic              somar,
    output logic [ATTR_W-1:0] resultado
);
    logic [ATTR_W+1:0] soma_s;
    logic [ATTR_W+1:0] dif_s;

    // Ten-bit intermediates keep both overflow and borrow visible in the top bits
    always_comb begin
        soma_s = {2'b00, operando} + {1'b0, delta};
        dif_s  = {2'b00, operando} - {1'b0, delta};
        if (somar) begin
            if (soma_s[ATTR_W+1:ATTR_W] != 2'b00) begin
                resultado = 8'hFF;
            end else begin
                resultado = soma_s[ATTR_W-1:0];
            end
        end else begin
            if (dif_s[ATTR_W+1:ATTR_W] != 2'b00) begin
                resultado = 8'h00;
            end else begin
                resultado = dif_s[ATTR_W-1:0];
            end
        end
    end
endmodule

// File: rtl/gerenciador_atributos.sv
// Pet attribute manager: periodic tick, then fome/felicidade/sono updated one per cycle
// through a single shared saturating adder, using the estado sampled at the tick.
module gerenciador_atributos
    import pacote_tamagotchi::*;
#(
    parameter int unsigned       TICK_CYCLES   = 32'd4194304,
    parameter logic [ATTR_W-1:0] VALOR_INICIAL = 8'd128,
    parameter logic [ATTR_W-1:0] DEC_FOME      = 8'd2,
    parameter logic [ATTR_W-1:0] DEC_FEL       = 8'd1,
    parameter logic [ATTR_W-1:0] DEC_SONO      = 8'd1,
    parameter logic [ATTR_W-1:0] INC_FOME      = 8'd16,
    parameter logic [ATTR_W-1:0] INC_FEL       = 8'd8,
    parameter logic [ATTR_W-1:0] INC_SONO      = 8'd12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        estado,
    output logic [ATTR_W-1:0] fome,
    output logic [ATTR_W-1:0] felicidade,
    output logic [ATTR_W-1:0] sono,
    output logic              atualizado,
    output logic              zerado
);
    localparam int CNT_W = (TICK_CYCLES > 32'd2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(TICK_CYCLES - 32'd1);

    typedef enum logic [1:0] {ESPERA, AT_FOME, AT_FEL, AT_SONO} fase_t;

    fase_t             fase_r;
    logic [CNT_W-1:0]  cont_r;
    logic [4:0]        estado_amostra_r;
    logic [ATTR_W-1:0] fome_r, fel_r, sono_r;
    logic              atualizado_r, zerado_r;

    logic              tick_s, intro_s;
    logic [ATTR_W-1:0] operando_s, resultado_s;
    logic [ATTR_W:0]   delta_s;
    logic              somar_s;
    logic [ATTR_W-1:0] fome_prox_s, fel_prox_s, sono_prox_s;

    assign tick_s  = (cont_r == ULTIMO);
    assign intro_s = (estado == INTRO);

    // Selects operand and rule for the attribute owned by the current FSM state
    always_comb begin
        operando_s = fome_r;
        delta_s    = 9'd0;
        somar_s    = 1'b0;
        case (fase_r)
            AT_FOME: begin
                operando_s = fome_r;
                case (estado_amostra_r)
                    COMENDO:    begin delta_s = {1'b0, INC_FOME}; somar_s = 1'b1; end
                    DANDO_AULA: delta_s = {DEC_FOME, 1'b0};
                    MORTO:      delta_s = 9'd0;
                    default:    delta_s = {1'b0, DEC_FOME};
                endcase
            end
            AT_FEL: begin
                operando_s = fel_r;
                case (estado_amostra_r)
                    DANDO_AULA: begin delta_s = {1'b0, INC_FEL}; somar_s = 1'b1; end
                    DORMINDO:   delta_s = 9'd0;
                    MORTO:      delta_s = 9'd0;
                    default:    delta_s = {1'b0, DEC_FEL};
                endcase
            end
            AT_SONO: begin
                operando_s = sono_r;
                case (estado_amostra_r)
                    DORMINDO:   begin delta_s = {1'b0, INC_SONO}; somar_s = 1'b1; end
                    DANDO_AULA: delta_s = {DEC_SONO, 1'b0};
                    MORTO:      delta_s = 9'd0;
                    default:    delta_s = {1'b0, DEC_SONO};
                endcase
            end
            default: begin
                operando_s = fome_r;
                delta_s    = 9'd0;
                somar_s    = 1'b0;
            end
        endcase
    end

    somador_saturado u_somador (
        .operando  (operando_s),
        .delta     (delta_s),
        .somar     (somar_s),
        .resultado (resultado_s)
    );

    // Next attribute values; zerado is derived from these so it moves with the attributes
    always_comb begin
        fome_prox_s = fome_r;
        fel_prox_s  = fel_r;
        sono_prox_s = sono_r;
        if (intro_s) begin
            fome_prox_s = VALOR_INICIAL;
            fel_prox_s  = VALOR_INICIAL;
            sono_prox_s = VALOR_INICIAL;
        end else if (fase_r == AT_FOME) begin
            fome_prox_s = resultado_s;
        end else if (fase_r == AT_FEL) begin
            fel_prox_s = resultado_s;
        end else if (fase_r == AT_SONO) begin
            sono_prox_s = resultado_s;
        end else begin
            fome_prox_s = fome_r;
        end
    end

    // Prescaler, update FSM and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cont_r           <= '0;
            fase_r           <= ESPERA;
            estado_amostra_r <= IDLE;
            fome_r           <= VALOR_INICIAL;
            fel_r            <= VALOR_INICIAL;
            sono_r           <= VALOR_INICIAL;
            atualizado_r     <= 1'b0;
            zerado_r         <= 1'b0;
        end else if (intro_s) begin
            cont_r       <= '0;
            fase_r       <= ESPERA;
            fome_r       <= fome_prox_s;
            fel_r        <= fel_prox_s;
            sono_r       <= sono_prox_s;
            atualizado_r <= 1'b0;
            zerado_r     <= (fome_prox_s == 8'd0) || (fel_prox_s == 8'd0) || (sono_prox_s == 8'd0);
        end else begin
            cont_r <= tick_s ? '0 : cont_r + CNT_W'(1);
            case (fase_r)
                ESPERA: begin
                    if (tick_s) begin
                        estado_amostra_r <= estado;
                        fase_r           <= AT_FOME;
                    end
                end
                AT_FOME: fase_r <= AT_FEL;
                AT_FEL:  fase_r <= AT_SONO;
                AT_SONO: fase_r <= ESPERA;
                default: fase_r <= ESPERA;
            endcase
            fome_r       <= fome_prox_s;
            fel_r        <= fel_prox_s;
            sono_r       <= sono_prox_s;
            atualizado_r <= (fase_r == AT_SONO);
            zerado_r     <= (fome_prox_s == 8'd0) || (fel_prox_s == 8'd0) || (sono_prox_s == 8'd0);
        end
    end

    assign fome       = fome_r;
    assign felicidade = fel_r;
    assign sono       = sono_r;
    assign atualizado = atualizado_r;
    assign zerado     = zerado_r;
endmodule

// File: tb/tb_gerenciador_atributos.sv
// Directed bench for gerenciador_atributos with TICK_CYCLES=8 (ticks at cycles 7, 15, 23, ...).
module tb_gerenciador_atributos;
    import pacote_tamagotchi::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] estado = IDLE;
    logic [7:0] fome, felicidade, sono;
    logic       atualizado, zerado;

    int n_checks = 0;
    int n_err    = 0;
    int ciclo    = 0;

    gerenciador_atributos #(.TICK_CYCLES(32'd8)) dut (
        .clk        (clk),
        .reset      (reset),
        .estado     (estado),
        .fome       (fome),
        .felicidade (felicidade),
        .sono       (sono),
        .atualizado (atualizado),
        .zerado     (zerado)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] est;
        int         f;
        int         fe;
        int         s;
    } vetor_t;

    vetor_t tabela [16];

    task automatic check(input string nome, input int real_v, input int esperado);
        n_checks++;
        if (real_v != esperado) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", nome, ciclo, real_v, esperado);
        end
    endtask

    task automatic check_attr(input string nome, input int f, input int fe, input int s);
        check({nome, ".fome"}, int'(fome), f);
        check({nome, ".felicidade"}, int'(felicidade), fe);
        check({nome, ".sono"}, int'(sono), s);
    endtask

    // Advance to the given cycle, landing 1 time unit after its rising edge
    task automatic advance_to(input int alvo);
        while (ciclo < alvo) begin
            @(posedge clk);
            ciclo++;
        end
        #1;
    endtask

    task automatic do_reset(input logic [4:0] e);
        reset = 1'b1;
        estado = e;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ciclo = 0;
    endtask

    initial begin
        tabela[0]  = '{IDLE,       126, 127, 127};
        tabela[1]  = '{COMENDO,    142, 126, 126};
        tabela[2]  = '{COMENDO,    158, 125, 125};
        tabela[3]  = '{DORMINDO,   156, 125, 137};
        tabela[4]  = '{DANDO_AULA, 152, 133, 135};
        tabela[5]  = '{MORTO,      152, 133, 135};
        tabela[6]  = '{5'b00011,   150, 132, 134};
        tabela[7]  = '{COMENDO,    166, 131, 133};
        tabela[8]  = '{COMENDO,    182, 130, 132};
        tabela[9]  = '{COMENDO,    198, 129, 131};
        tabela[10] = '{COMENDO,    214, 128, 130};
        tabela[11] = '{COMENDO,    230, 127, 129};
        tabela[12] = '{COMENDO,    246, 126, 128};
        tabela[13] = '{COMENDO,    255, 125, 127};
        tabela[14] = '{COMENDO,    255, 124, 126};
        tabela[15] = '{DORMINDO,   253, 124, 138};

        // Reset state
        do_reset(IDLE);
        @(negedge clk);
        check_attr("reset", 128, 128, 128);
        check("reset.atualizado", int'(atualizado), 0);
        check("reset.zerado", int'(zerado), 0);

        // One tick per vector; estado changes mid-period, results complete at 8i+11
        for (int i = 0; i < 16; i++) begin
            advance_to((i == 0) ? 0 : 8 * i + 4);
            estado = tabela[i].est;
            advance_to(8 * i + 10);
            @(negedge clk);
            check($sformatf("vec%0d.atualizado_pre", i), int'(atualizado), 0);
            advance_to(8 * i + 11);
            @(negedge clk);
            check_attr($sformatf("vec%0d", i), tabela[i].f, tabela[i].fe, tabela[i].s);
            check($sformatf("vec%0d.atualizado", i), int'(atualizado), 1);
            check($sformatf("vec%0d.zerado", i), int'(zerado), 0);
        end

        // Single-pulse timing of fome/felicidade/sono after the tick at cycle 7
        do_reset(IDLE);
        advance_to(8);
        @(negedge clk);
        check_attr("t8", 128, 128, 128);
        advance_to(9);
        @(negedge clk);
        check_attr("t9", 126, 128, 128);
        advance_to(10);
        @(negedge clk);
        check_attr("t10", 126, 127, 128);
        check("t10.atualizado", int'(atualizado), 0);
        advance_to(11);
        @(negedge clk);
        check_attr("t11", 126, 127, 127);
        check("t11.atualizado", int'(atualizado), 1);
        advance_to(12);
        @(negedge clk);
        check("t12.atualizado", int'(atualizado), 0);
        advance_to(14);
        @(negedge clk);
        check_attr("t14.hold", 126, 127, 127);

        // IDLE down to fome == 0, then saturation at zero
        advance_to(8 * 62 + 11);
        @(negedge clk);
        check_attr("idle63", 2, 65, 65);
        check("idle63.zerado", int'(zerado), 0);
        advance_to(512);
        @(negedge clk);
        check("idle64.t1.fome", int'(fome), 2);
        check("idle64.t1.zerado", int'(zerado), 0);
        advance_to(513);
        @(negedge clk);
        check("idle64.t2.fome", int'(fome), 0);
        check("idle64.t2.zerado", int'(zerado), 1);
        advance_to(8 * 64 + 11);
        @(negedge clk);
        check_attr("idle65", 0, 63, 63);
        check("idle65.zerado", int'(zerado), 1);
        advance_to(8 * 64 + 12);
        estado = DANDO_AULA;
        advance_to(8 * 65 + 11);
        @(negedge clk);
        check_attr("aula_sat0", 0, 71, 61);
        check("aula_sat0.zerado", int'(zerado), 1);

        // DANDO_AULA sampled; estado switched at T+2 must not mix rules
        do_reset(DANDO_AULA);
        advance_to(9);
        estado = DORMINDO;
        advance_to(11);
        @(negedge clk);
        check_attr("aula", 124, 136, 126);
        check("aula.atualizado", int'(atualizado), 1);
        advance_to(19);
        @(negedge clk);
        check_attr("dormindo_seg", 122, 136, 138);

        // INTRO at T+2 aborts sequence and restarts prescaler
        do_reset(IDLE);
        advance_to(9);
        estado = INTRO;
        advance_to(10);
        @(negedge clk);
        check_attr("intro", 128, 128, 128);
        check("intro.atualizado", int'(atualizado), 0);
        advance_to(11);
        estado = IDLE;
        @(negedge clk);
        check("intro.no_pulse", int'(atualizado), 0);
        advance_to(19);
        @(negedge clk);
        check("intro.restart_pre", int'(fome), 128);
        advance_to(20);
        @(negedge clk);
        check("intro.restart_fome", int'(fome), 126);

        // MORTO freezes attributes but still pulses atualizado
        do_reset(MORTO);
        for (int k = 0; k < 3; k++) begin
            advance_to(8 * k + 11);
            @(negedge clk);
            check_attr($sformatf("morto%0d", k), 128, 128, 128);
            check($sformatf("morto%0d.atualizado", k), int'(atualizado), 1);
            advance_to(8 * k + 12);
            @(negedge clk);
            check($sformatf("morto%0d.atualizado_pos", k), int'(atualizado), 0);
        end

        // Reset asserted mid-sequence
        advance_to(28);
        estado = IDLE;
        advance_to(33);
        @(negedge clk);
        check("rst_mid.pre_fome", int'(fome), 126);
        advance_to(33);
        reset = 1'b1;
        advance_to(34);
        reset = 1'b0;
        @(negedge clk);
        check_attr("rst_mid", 128, 128, 128);
        check("rst_mid.atualizado", int'(atualizado), 0);
        check("rst_mid.zerado", int'(zerado), 0);
        advance_to(35);
        @(negedge clk);
        check("rst_mid.no_pulse", int'(atualizado), 0);
        check_attr("rst_mid.hold", 128, 128, 128);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
